// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared state encodings and digit constants for the BCD converters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int DIGIT_W       = 4;
  localparam int CORR_THRESH   = 8;
  localparam int CORR_VAL      = 3;
  localparam int BCD_MAX_DIGIT = 9;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_corr.sv
// ============================================================================
// Module : bcd_digit_corr
// Brief  : Combinational single-digit dabble correction (>= THRESH -> -/+ CORR).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_corr
  import bcd_pkg::*;
#(
  parameter int THRESH   = CORR_THRESH,
  parameter int CORR     = CORR_VAL,
  parameter bit SUBTRACT = 1'b1
) (
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  localparam logic [DIGIT_W-1:0] c_thresh = DIGIT_W'(THRESH);
  localparam logic [DIGIT_W-1:0] c_corr   = DIGIT_W'(CORR);

  // SUBTRACT=0 with threshold 5 / +3 gives the forward-converter cell.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= c_thresh) begin
      o_digit = SUBTRACT ? (i_digit - c_corr) : (i_digit + c_corr);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd2bin.sv
// ============================================================================
// Module : bcd2bin
// Brief  : Packed-BCD to binary converter, reverse double-dabble FSM.
//          Optional invalid-digit check enabled by macro BCD2BIN_CHECK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*DIGITS-1:0]     bcd_in,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    rdy,
  output logic                    busy,
  output logic                    err
);

  localparam int c_bcd_w = DIGIT_W * DIGITS;
  localparam int c_sr_w  = c_bcd_w + BIN_W;
  localparam int c_cnt_w = $clog2(BIN_W + 1);

  logic [1:0]         r_state;
  logic [c_sr_w-1:0]  r_sr;
  logic [c_cnt_w-1:0] r_sh_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic               r_rdy;
  logic               r_busy;

  logic [c_bcd_w-1:0] w_corr_bcd;
  logic [c_sr_w-1:0]  w_sr_corr;
  logic [BIN_W-1:0]   w_result;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_digit (r_sr[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_corr_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Correction touches only the BCD field; the binary field passes through.
  assign w_sr_corr = {w_corr_bcd, r_sr[BIN_W-1:0]};

`ifdef BCD2BIN_CHECK_EN
  logic [DIGITS-1:0] w_digit_bad;
  logic              r_err;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign w_digit_bad[g] = bcd_in[g*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX_DIGIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && en) begin
      r_err <= |w_digit_bad;
    end
  end

  assign w_result = r_err ? '0 : r_sr[BIN_W-1:0];
  assign err      = r_err;
`else
  assign w_result = r_sr[BIN_W-1:0];
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_sh_cnt <= '0;
      r_bin    <= '0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b0;
          if (en) begin
            r_sr     <= {bcd_in, {BIN_W{1'b0}}};
            r_sh_cnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr     <= r_sr >> 1;
          r_sh_cnt <= r_sh_cnt + 1'b1;
          r_state  <= SUB;
        end
        SUB: begin
          r_sr    <= w_sr_corr;
          r_state <= (r_sh_cnt == c_cnt_w'(BIN_W)) ? DONE : SHIFT;
        end
        DONE: begin
          r_bin   <= w_result;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bin_out = r_bin;
  assign rdy     = r_rdy;
  assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin.sv
// ============================================================================
// Module : tb_bcd2bin
// Brief  : Directed self-checking bench for bcd2bin (default parameters).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd2bin;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] bcd_in;
  logic [13:0] bin_out;
  logic        rdy;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  bcd2bin #(.DIGITS(4), .BIN_W(14)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .rdy     (rdy),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single start pulse; bcd_in is scrambled right after acceptance.
  task automatic convert(input string tag, input logic [15:0] bcd,
                         input logic [13:0] exp_bin, input logic exp_err);
    int lat;
    int nbusy;
    bcd_in = bcd;
    en     = 1'b1;
    tick();
    en     = 1'b0;
    bcd_in = ~bcd;
    check({tag, "_busy0"}, busy, 1);
    lat   = 0;
    nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) nbusy++;
      if (k == 1) check({tag, "_err"}, err, exp_err);
      if (rdy) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, 29);
    check({tag, "_busycnt"}, nbusy, 28);
    check({tag, "_bin"}, bin_out, exp_bin);
    check({tag, "_errdone"}, err, exp_err);
    tick();
    check({tag, "_rdypulse"}, rdy, 0);
  endtask

  initial begin
    int lat;
    int nrdy;
    logic [15:0] cur;
    logic [13:0] exp_v;

    rst_n  = 1'b0;
    en     = 1'b0;
    bcd_in = 16'h0000;
    #3;
    check("rst_bin", bin_out, 0);
    check("rst_rdy", rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    convert("c9999", 16'h9999, 14'd9999, 1'b0);
    convert("c0000", 16'h0000, 14'd0, 1'b0);
    convert("c1234", 16'h1234, 14'h04D2, 1'b0);
    convert("c4095", 16'h4095, 14'h0FFF, 1'b0);

    // Back-to-back with en held high, alternating operands.
    cur    = 16'h0001;
    bcd_in = cur;
    en     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_v  = (cur == 16'h0001) ? 14'd1 : 14'd10;
      cur    = (cur == 16'h0001) ? 16'h0010 : 16'h0001;
      bcd_in = cur;
      if (i == 3) en = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (k == 10) bcd_in = 16'h9999;
        if (k == 11) bcd_in = cur;
        if (rdy) begin
          lat = k;
          break;
        end
      end
      check("b2b_lat", lat, 29);
      check("b2b_bin", bin_out, exp_v);
    end
    en = 1'b0;
    tick();

    // Reset asserted mid-conversion.
    bcd_in = 16'h5678;
    en     = 1'b1;
    tick();
    en = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_bin", bin_out, 0);
    tick();
    tick();
    rst_n = 1'b1;
    nrdy  = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rdy) nrdy++;
    end
    check("mid_rst_nordy", nrdy, 0);
    check("mid_rst_bin2", bin_out, 0);
    check("mid_rst_busy2", busy, 0);
    convert("c5678", 16'h5678, 14'd5678, 1'b0);

`ifdef BCD2BIN_CHECK_EN
    convert("bad12A4", 16'h12A4, 14'd0, 1'b1);
`else
    // Unchecked: digits are weighted arithmetically, 1000+200+10*10+4.
    convert("bad12A4", 16'h12A4, 14'd1304, 1'b0);
`endif
    convert("c0042", 16'h0042, 14'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
